// File: rtl/led_pkg.sv
// Shared definitions for the LED display blocks: phase state encoding and default sizes.
package led_pkg;

    typedef logic [1:0] led_state_t;

    localparam led_state_t ST_DEAD_A   = 2'd0;
    localparam led_state_t ST_PHASE_YR = 2'd1;
    localparam led_state_t ST_DEAD_B   = 2'd2;
    localparam led_state_t ST_PHASE_BG = 2'd3;

    localparam int LED_N_DEFAULT        = 12;
    localparam int LED_BRIGHT_W_DEFAULT = 4;

    // Counter width helper that never collapses to a zero-width vector.
    function automatic int clog2_min1(input int value);
        return (value <= 2) ? 1 : $clog2(value);
    endfunction

endpackage

// File: rtl/led_phase_timer.sv
// Frame sequencer: DEAD_A -> PHASE_YR -> DEAD_B -> PHASE_BG, one shared down-counter
// plus an up-counting position within the current colour phase.
module led_phase_timer
    import led_pkg::*;
#(
    parameter int PHASE_CYCLES = 4096,
    parameter int DEAD_CYCLES  = 16,
    parameter int PH_W         = clog2_min1(PHASE_CYCLES)
) (
    input  logic            clk_12,
    input  logic            rst,
    output led_state_t      state,
    output logic [PH_W-1:0] ph_cnt,
    output logic            capture
);

    localparam int CNT_MAX = (PHASE_CYCLES > DEAD_CYCLES) ? PHASE_CYCLES : DEAD_CYCLES;
    localparam int CNT_W   = clog2_min1(CNT_MAX);

    localparam logic [CNT_W-1:0] PHASE_LOAD = CNT_W'(PHASE_CYCLES - 1);
    localparam logic [CNT_W-1:0] DEAD_LOAD  = CNT_W'(DEAD_CYCLES - 1);

    led_state_t      state_reg, state_next;
    logic [CNT_W-1:0] cnt_reg, cnt_next;
    logic [PH_W-1:0]  ph_cnt_reg, ph_cnt_next;

    always_ff @(posedge clk_12) begin
        if (rst) begin
            state_reg  <= ST_DEAD_A;
            cnt_reg    <= DEAD_LOAD;
            ph_cnt_reg <= '0;
        end else begin
            state_reg  <= state_next;
            cnt_reg    <= cnt_next;
            ph_cnt_reg <= ph_cnt_next;
        end
    end

    // ph_cnt only runs inside a colour phase, so it is back at 0 on every phase entry.
    always_comb begin
        state_next  = state_reg;
        cnt_next    = cnt_reg - 1'b1;
        ph_cnt_next = '0;
        if (state_reg == ST_PHASE_YR || state_reg == ST_PHASE_BG) begin
            ph_cnt_next = ph_cnt_reg + 1'b1;
        end
        if (cnt_reg == '0) begin
            ph_cnt_next = '0;
            case (state_reg)
                ST_DEAD_A: begin
                    state_next = ST_PHASE_YR;
                    cnt_next   = PHASE_LOAD;
                end
                ST_PHASE_YR: begin
                    state_next = ST_DEAD_B;
                    cnt_next   = DEAD_LOAD;
                end
                ST_DEAD_B: begin
                    state_next = ST_PHASE_BG;
                    cnt_next   = PHASE_LOAD;
                end
                default: begin
                    state_next = ST_DEAD_A;
                    cnt_next   = DEAD_LOAD;
                end
            endcase
        end
    end

    // The first DEAD_A cycle is the only one where the counter still holds its load value.
    always_comb begin
        state   = state_reg;
        ph_cnt  = ph_cnt_reg;
        capture = (state_reg == ST_DEAD_A) && (cnt_reg == DEAD_LOAD);
    end

endmodule

// File: rtl/bicolour_led_drv.sv
// Bicolour LED bank driver: per-frame input capture, shared PWM duty and registered
// tristate pin/enable outputs that alternate the two colours with dead time between them.
module bicolour_led_drv
    import led_pkg::*;
#(
    parameter int N            = LED_N_DEFAULT,
    parameter int PHASE_CYCLES = 4096,
    parameter int DEAD_CYCLES  = 16,
    parameter int BRIGHT_W     = LED_BRIGHT_W_DEFAULT
) (
    input  logic                clk_12,
    input  logic                rst,
    input  logic [N-1:0]        led_in_yr,
    input  logic [N-1:0]        led_in_bg,
    input  logic [BRIGHT_W-1:0] bright,
    output logic [N-1:0]        led_pin,
    output logic [N-1:0]        led_oe,
    output logic                frame_start
);

    localparam int PH_W = clog2_min1(PHASE_CYCLES);
    localparam logic [PH_W-1:0] PWM_MASK = PH_W'((1 << BRIGHT_W) - 1);

    led_state_t      state;
    logic [PH_W-1:0] ph_cnt;
    logic            capture;

    logic [N-1:0]        yr_q, bg_q;
    logic [BRIGHT_W-1:0] br_q;
    logic                pwm_on;
    logic                in_yr, in_bg;
    logic [N-1:0]        oe_next, pin_next;
    logic [N-1:0]        led_oe_reg, led_pin_reg;
    logic                frame_start_reg;

    led_phase_timer #(
        .PHASE_CYCLES (PHASE_CYCLES),
        .DEAD_CYCLES  (DEAD_CYCLES),
        .PH_W         (PH_W)
    ) u_timer (
        .clk_12  (clk_12),
        .rst     (rst),
        .state   (state),
        .ph_cnt  (ph_cnt),
        .capture (capture)
    );

    // Masking keeps the duty pattern aligned to each phase start; PHASE_CYCLES is a
    // multiple of the PWM period so every phase sees whole PWM periods.
    always_comb begin
        pwm_on = (ph_cnt & PWM_MASK) < PH_W'(br_q);
        in_yr  = (state == ST_PHASE_YR);
        in_bg  = (state == ST_PHASE_BG);
    end

    // Pins only move when a phase starts, and the dead states in front of every phase
    // keep oe low, so no pin ever switches level while it is driven.
    for (genvar gi = 0; gi < N; gi++) begin : g_pin
        always_comb begin
            oe_next[gi]  = ((in_yr && yr_q[gi]) || (in_bg && bg_q[gi])) && pwm_on;
            pin_next[gi] = led_pin_reg[gi];
            if (in_yr) begin
                pin_next[gi] = 1'b1;
            end else if (in_bg) begin
                pin_next[gi] = 1'b0;
            end
        end
    end

    always_ff @(posedge clk_12) begin
        if (rst) begin
            yr_q            <= '0;
            bg_q            <= '0;
            br_q            <= '0;
            led_oe_reg      <= '0;
            led_pin_reg     <= '0;
            frame_start_reg <= 1'b0;
        end else begin
            if (capture) begin
                yr_q <= led_in_yr;
                bg_q <= led_in_bg;
                br_q <= bright;
            end
            led_oe_reg      <= oe_next;
            led_pin_reg     <= pin_next;
            frame_start_reg <= capture;
        end
    end

    assign led_oe      = led_oe_reg;
    assign led_pin     = led_pin_reg;
    assign frame_start = frame_start_reg;

endmodule

// File: tb/tb_bicolour_led_drv.sv
// Directed bench for bicolour_led_drv with a short frame: 2 dead + 32 phase cycles per colour.
module tb_bicolour_led_drv;

    localparam int N  = 12;
    localparam int PH = 32;
    localparam int DC = 2;
    localparam int BW = 4;

    logic          clk_12 = 1'b0;
    logic          rst = 1'b1;
    logic [N-1:0]  led_in_yr = '0;
    logic [N-1:0]  led_in_bg = '0;
    logic [BW-1:0] bright = '0;
    logic [N-1:0]  led_pin;
    logic [N-1:0]  led_oe;
    logic          frame_start;

    int n_checks = 0;
    int n_fail   = 0;

    bicolour_led_drv #(
        .N            (N),
        .PHASE_CYCLES (PH),
        .DEAD_CYCLES  (DC),
        .BRIGHT_W     (BW)
    ) dut (
        .clk_12      (clk_12),
        .rst         (rst),
        .led_in_yr   (led_in_yr),
        .led_in_bg   (led_in_bg),
        .bright      (bright),
        .led_pin     (led_pin),
        .led_oe      (led_oe),
        .frame_start (frame_start)
    );

    always #5 clk_12 = ~clk_12;

    // Sample 1 time unit after the rising edge. After reset_dut returns, the next
    // step() samples the outputs of frame cycle j=1 (the capture cycle).
    task automatic step();
        @(posedge clk_12);
        #1;
    endtask

    task automatic reset_dut();
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        int on_yr = 0, oe_bg = 0, fs_extra = 0, first_oe = -1;
        logic oe18 = 1'b1;
        led_in_yr = 12'h001; led_in_bg = 12'h000; bright = 4'd15;
        rst = 1'b1;
        step();
        n_checks++;
        if (led_oe !== 12'h000) begin n_fail++; $display("FAIL reset_oe: got %h expected 000", led_oe); end
        n_checks++;
        if (led_pin !== 12'h000) begin n_fail++; $display("FAIL reset_pin: got %h expected 000", led_pin); end
        n_checks++;
        if (frame_start !== 1'b0) begin n_fail++; $display("FAIL reset_fs: got %b expected 0", frame_start); end
        rst = 1'b0;
        step();
        n_checks++;
        if (frame_start !== 1'b1) begin n_fail++; $display("FAIL first_fs: got %b expected 1", frame_start); end
        for (int j = 2; j <= 69; j++) begin
            step();
            if (j <= 68 && frame_start === 1'b1) fs_extra++;
            if (led_oe[0] === 1'b1 && first_oe < 0) first_oe = j;
            if (j >= 3 && j <= 34 && led_oe[0] === 1'b1 && led_pin[0] === 1'b1) on_yr++;
            if (j >= 37 && j <= 68 && led_oe[0] !== 1'b0) oe_bg++;
            if (j == 18) oe18 = led_oe[0];
        end
        n_checks++;
        if (frame_start !== 1'b1) begin n_fail++; $display("FAIL second_fs: got %b expected 1", frame_start); end
        n_checks++;
        if (fs_extra != 0) begin n_fail++; $display("FAIL fs_extra: got %0d expected 0", fs_extra); end
        n_checks++;
        if (first_oe != 3) begin n_fail++; $display("FAIL first_oe_cycle: got %0d expected 3", first_oe); end
        n_checks++;
        if (on_yr != 30) begin n_fail++; $display("FAIL yr_on_cycles: got %0d expected 30", on_yr); end
        n_checks++;
        if (oe18 !== 1'b0) begin n_fail++; $display("FAIL pwm_off_ph15: got %b expected 0", oe18); end
        n_checks++;
        if (oe_bg != 0) begin n_fail++; $display("FAIL oe_in_bg: got %0d expected 0", oe_bg); end
        $display("test_reset done");
    endtask

    task automatic test_bg_only();
        int bg_on = 0, other = 0, yr_oe = 0;
        led_in_yr = 12'h000; led_in_bg = 12'h800; bright = 4'd4;
        reset_dut();
        for (int j = 1; j <= 68; j++) begin
            step();
            if (j >= 37 && led_oe === 12'h800 && led_pin[11] === 1'b0) bg_on++;
            if ((led_oe & 12'h7FF) !== 12'h000) other++;
            if (j <= 34 && led_oe !== 12'h000) yr_oe++;
        end
        n_checks++;
        if (bg_on != 8) begin n_fail++; $display("FAIL bg_on_cycles: got %0d expected 8", bg_on); end
        n_checks++;
        if (other != 0) begin n_fail++; $display("FAIL bg_other_bits: got %0d expected 0", other); end
        n_checks++;
        if (yr_oe != 0) begin n_fail++; $display("FAIL bg_yr_phase_oe: got %0d expected 0", yr_oe); end
        $display("test_bg_only done");
    endtask

    task automatic test_mix();
        int viol = 0, yr_on = 0, bg_on = 0, pin_chg = 0;
        int last_fall[N];
        logic [N-1:0] prev_oe = '0, prev_pin = '0;
        led_in_yr = 12'hFFF; led_in_bg = 12'hFFF; bright = 4'd8;
        for (int i = 0; i < N; i++) last_fall[i] = -1000;
        reset_dut();
        for (int j = 1; j <= 136; j++) begin
            step();
            for (int i = 0; i < N; i++) begin
                if (prev_oe[i] === 1'b1 && led_oe[i] === 1'b0) last_fall[i] = j;
                if (led_pin[i] !== prev_pin[i]) begin
                    pin_chg++;
                    if (prev_oe[i] !== 1'b0 || (j - last_fall[i]) < 2) viol++;
                end
                if (j >= 3 && j <= 34 && led_oe[i] === 1'b1) yr_on++;
                if (j >= 37 && j <= 68 && led_oe[i] === 1'b1) bg_on++;
            end
            prev_oe  = led_oe;
            prev_pin = led_pin;
        end
        n_checks++;
        if (viol != 0) begin n_fail++; $display("FAIL mix_break_before_make: got %0d violations expected 0", viol); end
        n_checks++;
        if (pin_chg != 48) begin n_fail++; $display("FAIL mix_pin_changes: got %0d expected 48", pin_chg); end
        n_checks++;
        if (yr_on != 192) begin n_fail++; $display("FAIL mix_yr_on: got %0d expected 192", yr_on); end
        n_checks++;
        if (bg_on != 192) begin n_fail++; $display("FAIL mix_bg_on: got %0d expected 192", bg_on); end
        $display("test_mix done");
    endtask

    task automatic test_capture();
        int a_on = 0, a_bad = 0, b_on = 0, b_bad = 0;
        logic fs69 = 1'b0;
        led_in_yr = 12'h0F0; led_in_bg = 12'h000; bright = 4'd15;
        reset_dut();
        for (int j = 1; j <= 102; j++) begin
            step();
            if (j == 10) led_in_yr = 12'h00F;
            if (j == 69) fs69 = frame_start;
            if (j >= 3 && j <= 34) begin
                if (led_oe === 12'h0F0) a_on++;
                if ((led_oe & 12'hF0F) !== 12'h000) a_bad++;
            end
            if (j >= 71 && j <= 102) begin
                if (led_oe === 12'h00F) b_on++;
                if ((led_oe & 12'hFF0) !== 12'h000) b_bad++;
            end
        end
        n_checks++;
        if (a_on != 30) begin n_fail++; $display("FAIL cap_old_on: got %0d expected 30", a_on); end
        n_checks++;
        if (a_bad != 0) begin n_fail++; $display("FAIL cap_old_bits: got %0d expected 0", a_bad); end
        n_checks++;
        if (fs69 !== 1'b1) begin n_fail++; $display("FAIL cap_frame_start: got %b expected 1", fs69); end
        n_checks++;
        if (b_on != 30) begin n_fail++; $display("FAIL cap_new_on: got %0d expected 30", b_on); end
        n_checks++;
        if (b_bad != 0) begin n_fail++; $display("FAIL cap_new_bits: got %0d expected 0", b_bad); end
        $display("test_capture done");
    endtask

    task automatic test_bright0();
        int oe_any = 0, fs_cnt = 0;
        led_in_yr = 12'hFFF; led_in_bg = 12'hFFF; bright = 4'd0;
        reset_dut();
        for (int j = 1; j <= 204; j++) begin
            step();
            if (led_oe !== 12'h000) oe_any++;
            if (frame_start === 1'b1) fs_cnt++;
        end
        n_checks++;
        if (oe_any != 0) begin n_fail++; $display("FAIL bright0_oe: got %0d expected 0", oe_any); end
        n_checks++;
        if (fs_cnt != 3) begin n_fail++; $display("FAIL bright0_frames: got %0d expected 3", fs_cnt); end
        $display("test_bright0 done");
    endtask

    task automatic test_rst_mid();
        led_in_yr = 12'hFFF; led_in_bg = 12'hFFF; bright = 4'd15;
        reset_dut();
        for (int j = 1; j <= 50; j++) step();
        n_checks++;
        if (led_oe !== 12'hFFF) begin n_fail++; $display("FAIL mid_bg_oe: got %h expected fff", led_oe); end
        rst = 1'b1;
        step();
        n_checks++;
        if (led_oe !== 12'h000) begin n_fail++; $display("FAIL mid_rst_oe: got %h expected 000", led_oe); end
        n_checks++;
        if (led_pin !== 12'h000) begin n_fail++; $display("FAIL mid_rst_pin: got %h expected 000", led_pin); end
        n_checks++;
        if (frame_start !== 1'b0) begin n_fail++; $display("FAIL mid_rst_fs0: got %b expected 0", frame_start); end
        rst = 1'b0;
        step();
        n_checks++;
        if (frame_start !== 1'b1) begin n_fail++; $display("FAIL mid_rst_fs1: got %b expected 1", frame_start); end
        for (int j = 2; j <= 20; j++) step();
        n_checks++;
        if (led_pin !== 12'hFFF) begin n_fail++; $display("FAIL mid_yr_pin: got %h expected fff", led_pin); end
        n_checks++;
        if (led_oe !== 12'hFFF) begin n_fail++; $display("FAIL mid_yr_oe: got %h expected fff", led_oe); end
        rst = 1'b1;
        step();
        n_checks++;
        if (led_pin !== 12'h000) begin n_fail++; $display("FAIL yr_rst_pin: got %h expected 000", led_pin); end
        n_checks++;
        if (led_oe !== 12'h000) begin n_fail++; $display("FAIL yr_rst_oe: got %h expected 000", led_oe); end
        rst = 1'b0;
        $display("test_rst_mid done");
    endtask

    initial begin
        test_reset();
        test_bg_only();
        test_mix();
        test_capture();
        test_bright0();
        test_rst_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/bicolour_led_drv.md
# bicolour_led_drv

Drives a bank of bidirectional bicolour LEDs, one LED pair per pin, from two per-pin colour request vectors, time-multiplexing the two colours. Takes the yellow/red and blue/green request vectors that the display logic (scroller and similar pattern generators) produces each `clk_12` cycle. Drives the board LED pins through per-pin tristate buffers. Adds global PWM brightness and break-before-make dead time between colour phases. Inputs are sampled once per frame so every pattern stays glitch-free.

## Interface
- `N`, 12: number of LED pins.
- `PHASE_CYCLES`, 4096: clock cycles per colour phase. Must be a multiple of 2^`BRIGHT_W`.
- `DEAD_CYCLES`, 16: clock cycles with all pins released before each phase. Must be ≥1.
- `BRIGHT_W`, 4: brightness word width.

Ports:
- `clk_12`  in  1  system clock. Single clock domain.
- `rst`  in  1  reset. Synchronous, active-high.
- `led_in_yr`  in  N  request for the yellow/red colour per pin (pin driven high).
- `led_in_bg`  in  N  request for the blue/green colour per pin (pin driven low).
- `bright`  in  BRIGHT_W  global duty: 0 = off, 2^BRIGHT_W−1 = (2^BRIGHT_W−1)/2^BRIGHT_W on.
- `led_pin`  out  N  pin drive level.
- `led_oe`  out  N  pin output enable. 0 = tristate, LED off.
- `frame_start`  out  1  one-cycle pulse; the first cycle after the inputs are captured.

## Operation
- FSM states:
  - `DEAD_A`: `DEAD_CYCLES` cycles.
  - `PHASE_YR`: `PHASE_CYCLES` cycles.
  - `DEAD_B`: `DEAD_CYCLES` cycles.
  - `PHASE_BG`: `PHASE_CYCLES` cycles.
  - The FSM then returns to `DEAD_A`.
  - Frame length = 2·(DEAD_CYCLES+PHASE_CYCLES).
- One down-counter `cnt` is shared by all states. It loads the state length−1 on every state entry and advances the state when it reaches 0.
- Capture: on the clock edge that ends the cycle in which state = `DEAD_A` and it is the first cycle of `DEAD_A`, `led_in_yr`, `led_in_bg` and `bright` load into the frame registers `yr_q`, `bg_q` and `br_q`. Input changes at any other time are ignored until the next frame.
- PWM: `pwm_on = (ph_cnt[BRIGHT_W-1:0] < br_q)`.
  - `ph_cnt` counts up from 0 within the phase.
  - The PWM pattern therefore restarts identically in every phase.
  - Both colours receive the same duty.
- Per-state output:
  - `PHASE_YR`: pin = 1, oe = `yr_q & {N{pwm_on}}`.
  - `PHASE_BG`: pin = 0, oe = `bg_q & {N{pwm_on}}`.
  - `DEAD_*`: oe = 0; pin holds its last value. A pin never changes level while its oe = 1.
- Both `yr_q[i]` and `bg_q[i]` set: the pin shows both colours alternately (perceived mix). Neither set: the pin is never driven.

## Timing
- Reset values:
  - state = `DEAD_A`, counters at the start of `DEAD_A`.
  - `yr_q`/`bg_q`/`br_q` = 0.
  - `led_oe` = 0, `led_pin` = 0, `frame_start` = 0.
- `rst` asserted mid-frame: outputs read reset values on the next cycle. The frame restarts from `DEAD_A`.
- Outputs are registered and lag the FSM state by exactly 1 cycle.
- `frame_start` is high during the first cycle after the capture edge, once per frame. The first pulse occurs 2 cycles after `rst` deasserts.
- First possible `led_oe` = 1 occurs `DEAD_CYCLES`+1 cycles after the capture edge.
- `bright` = 0: `led_oe` stays 0 for the whole frame.

## Structure
- Shared package `led_pkg`: state encoding localparams (`ST_DEAD_A`, `ST_PHASE_YR`, `ST_DEAD_B`, `ST_PHASE_BG`) and default `N`/`BRIGHT_W`, shared with other LED display blocks.
- One sub-module, `led_phase_timer`: owns the FSM and the counters. Outputs `state`, `ph_cnt` and `capture`. The top level holds the frame registers and the output logic.

## Test plan
Bench parameters: `PHASE_CYCLES`=32, `DEAD_CYCLES`=2, `BRIGHT_W`=4, `N`=12.
- Reset release, `bright`=15, yr=`12'h001`, bg=0:
  - `frame_start` pulses at cycle 2.
  - `led_oe[0]`=1 with `led_pin[0]`=1 for 30 of 32 cycles in `PHASE_YR`: `ph_cnt[3:0]` = 0..14 on, 15 off, twice per phase.
  - `led_oe[0]`=0 throughout `PHASE_BG`.
- yr=0, bg=`12'h800`, `bright`=4: `led_oe[11]`=1 with `led_pin[11]`=0 for exactly 8 cycles per `PHASE_BG`. All other oe bits stay 0.
- yr=bg=`12'hFFF`, `bright`=8: every `led_oe` transition 1→0 precedes any `led_pin` change by ≥2 cycles. Each pin shows 16 on-cycles per phase.
- Change `led_in_yr` from `12'h0F0` to `12'h00F` mid-`PHASE_YR`: output stays `12'h0F0` until the next `frame_start`, then becomes `12'h00F`.
- `bright`=0, all inputs `12'hFFF`: `led_oe` = 0 for 3 full frames.
- Assert `rst` for 1 cycle during `PHASE_BG`: next cycle `led_oe`=0, `led_pin`=0. `frame_start` pulses 2 cycles after `rst` falls.
